// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive engines:
//   - frame state encoding (legacy-compatible 3-bit constants)
//   - data-length (DLS) encodings
//   - default oversample factor and baud divisor width
//   - helper functions for data masking, parity and last data-bit index
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DIV_W_DEF      = 12;

  // Frame state encoding, shared by TX and RX sequencers
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP1  = 3'd4;
  localparam uart_state_t ST_STOP2  = 3'd5;

  // Data length select encodings
  localparam logic [1:0] DLS_5 = 2'd0;
  localparam logic [1:0] DLS_6 = 2'd1;
  localparam logic [1:0] DLS_7 = 2'd2;
  localparam logic [1:0] DLS_8 = 2'd3;

  // Mask selecting the data bits that are actually sent for a given DLS
  function automatic logic [7:0] uart_data_mask(input logic [1:0] dls);
    logic [7:0] mask;
    case (dls)
      DLS_5:   mask = 8'h1F;
      DLS_6:   mask = 8'h3F;
      DLS_7:   mask = 8'h7F;
      DLS_8:   mask = 8'hFF;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Parity over the sent data bits only; eps=1 even, eps=0 odd
  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic [1:0] dls,
                                       input logic       eps);
    logic red;
    red = ^(data & uart_data_mask(dls));
    return eps ? red : ~red;
  endfunction

  // Index of the last data bit: 4 for 5-bit characters up to 7 for 8-bit
  function automatic logic [2:0] uart_last_bit(input logic [1:0] dls);
    return 3'd4 + {1'b0, dls};
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. An inner divider counts i_div+1 clocks per oversample
// step; an outer counter counts OVERSAMPLE steps per bit. The bit period is
// therefore OVERSAMPLE*(i_div+1) clocks. Counting runs only while i_en is
// high; i_clr synchronously returns both counters to zero.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_clr       synchronous clear of both counters (dominates i_en)
//   i_en        count enable
//   i_div       baud divisor
//   o_bit_tick  1-cycle pulse on the last clock of each bit period
//   o_mid_tick  1-cycle pulse at the end of the first half bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W      = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bit_tick,
  output logic             o_mid_tick
);

  localparam int             OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [OS_W-1:0]  r_os_cnt;
  logic             w_step;

  // An oversample step completes when the inner divider reaches the divisor
  assign w_step     = i_en && (r_div_cnt == i_div);
  assign o_bit_tick = w_step && (r_os_cnt == OS_LAST);
  assign o_mid_tick = w_step && (r_os_cnt == OS_MID);

  // Divider and oversample counters; explicit wrap to zero keeps
  // non-power-of-two OVERSAMPLE values and the full divisor range glitch-free
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_os_cnt  <= {OS_W{1'b0}};
    end else if (i_clr) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_os_cnt  <= {OS_W{1'b0}};
    end else if (w_step) begin
      r_div_cnt <= {DIV_W{1'b0}};
      if (r_os_cnt == OS_LAST) begin
        r_os_cnt <= {OS_W{1'b0}};
      end else begin
        r_os_cnt <= r_os_cnt + OS_W'(1);
      end
    end else if (i_en) begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt;
      r_os_cnt  <= r_os_cnt;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// Serial transmit engine. On an accepted TxStart the character and frame
// format are captured into shadow registers and one frame is shifted out on
// TxD: start bit, 5..8 data bits LSB first, optional parity, one or two stop
// bits. Each bit lasts OVERSAMPLE*(BaudDiv+1) clocks.
// Ports:
//   pClk     clock
//   pReset   asynchronous active-low reset
//   TxEn     transmitter enable (gates acceptance only)
//   TxStart  1-cycle send request
//   TxData   character to send
//   DLS      data length select (0=5 .. 3=8 bits)
//   STOP     0=one stop bit, 1=two stop bits
//   PEN      parity enable
//   EPS      1=even parity, 0=odd parity
//   BaudDiv  baud divisor
//   TxD      registered serial output, idle high
//   TxBusy   frame in progress
//   TxDone   1-cycle pulse when the final stop bit ends
// -----------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W      = DIV_W_DEF
) (
  input  logic             pClk,
  input  logic             pReset,
  input  logic             TxEn,
  input  logic             TxStart,
  input  logic [7:0]       TxData,
  input  logic [1:0]       DLS,
  input  logic             STOP,
  input  logic             PEN,
  input  logic             EPS,
  input  logic [DIV_W-1:0] BaudDiv,
  output logic             TxD,
  output logic             TxBusy,
  output logic             TxDone
);

  uart_state_t      r_state;
  logic [7:0]       r_shift;
  logic [1:0]       r_dls;
  logic             r_stop;
  logic             r_pen;
  logic             r_par;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_cnt;
  logic             r_txd;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_bit_tick;
  logic             w_mid_tick_unused;
  logic [2:0]       w_last_bit;

  assign w_accept   = TxStart && TxEn && (r_state == ST_IDLE);
  assign w_last_bit = uart_last_bit(r_dls);

  assign TxD    = r_txd;
  assign TxBusy = r_busy;
  assign TxDone = r_done;

  // Bit timer runs only during a frame and restarts on every accepted request
  uart_baud_gen #(
    .OVERSAMPLE (OVERSAMPLE),
    .DIV_W      (DIV_W)
  ) u_baud_gen (
    .i_clk      (pClk),
    .i_rst_n    (pReset),
    .i_clr      (w_accept),
    .i_en       (r_busy),
    .i_div      (r_div),
    .o_bit_tick (w_bit_tick),
    .o_mid_tick (w_mid_tick_unused)
  );

  // Shadow capture of character and format on acceptance; parity is computed
  // up front so later input changes cannot affect the frame in flight
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      r_dls  <= 2'd0;
      r_stop <= 1'b0;
      r_pen  <= 1'b0;
      r_par  <= 1'b0;
      r_div  <= {DIV_W{1'b0}};
    end else if (w_accept) begin
      r_dls  <= DLS;
      r_stop <= STOP;
      r_pen  <= PEN;
      r_par  <= uart_parity(TxData, DLS, EPS);
      r_div  <= BaudDiv;
    end else begin
      r_dls  <= r_dls;
      r_stop <= r_stop;
      r_pen  <= r_pen;
      r_par  <= r_par;
      r_div  <= r_div;
    end
  end

  // Frame sequencer: every non-idle state advances on the bit tick, and TxD
  // is loaded with the value of the state being entered
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_START;
            r_shift   <= TxData;
            r_bit_cnt <= 3'd0;
            r_txd     <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_txd  <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_tick) begin
            r_state   <= ST_DATA;
            r_txd     <= r_shift[0];
            r_bit_cnt <= 3'd0;
          end else begin
            r_state <= ST_START;
          end
        end
        ST_DATA: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == w_last_bit) begin
              if (r_pen) begin
                r_state <= ST_PARITY;
                r_txd   <= r_par;
              end else begin
                r_state <= ST_STOP1;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_PARITY: begin
          if (w_bit_tick) begin
            r_state <= ST_STOP1;
            r_txd   <= 1'b1;
          end else begin
            r_state <= ST_PARITY;
          end
        end
        ST_STOP1: begin
          if (w_bit_tick) begin
            if (r_stop) begin
              r_state <= ST_STOP2;
              r_txd   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= ST_STOP1;
          end
        end
        ST_STOP2: begin
          if (w_bit_tick) begin
            r_state <= ST_IDLE;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_STOP2;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed bench for uart_tx_engine. Each frame is checked bit by bit against
// a hand-computed, LSB-first expected bit vector (bit 0 = start bit), along
// with bit-period length, TxBusy, and the TxDone pulse position.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

  logic        pClk = 1'b0;
  logic        pReset;
  logic        TxEn;
  logic        TxStart;
  logic [7:0]  TxData;
  logic [1:0]  DLS;
  logic        STOP;
  logic        PEN;
  logic        EPS;
  logic [11:0] BaudDiv;
  logic        TxD;
  logic        TxBusy;
  logic        TxDone;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_engine #(
    .OVERSAMPLE (16),
    .DIV_W      (12)
  ) dut (
    .pClk    (pClk),
    .pReset  (pReset),
    .TxEn    (TxEn),
    .TxStart (TxStart),
    .TxData  (TxData),
    .DLS     (DLS),
    .STOP    (STOP),
    .PEN     (PEN),
    .EPS     (EPS),
    .BaudDiv (BaudDiv),
    .TxD     (TxD),
    .TxBusy  (TxBusy),
    .TxDone  (TxDone)
  );

  always #5 pClk = ~pClk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Starts a frame from a negedge and follows it to the TxDone negedge.
  // mode 1: mid-frame TxStart with different data/format/divisor
  // mode 2: TxEn dropped mid-frame
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [1:0] dls,
                           input logic stop, input logic pen, input logic eps,
                           input logic [11:0] div, input logic [11:0] exp_bits,
                           input int nbits, input int mode);
    int   p;
    int   t;
    logic first_v;
    logic stable;
    logic busy_ok;
    logic done_early;
    p = 16 * (int'(div) + 1);
    t = nbits * p;
    TxEn = 1'b1; TxData = data; DLS = dls; STOP = stop; PEN = pen; EPS = eps;
    BaudDiv = div; TxStart = 1'b1;
    @(negedge pClk);
    TxStart    = 1'b0;
    busy_ok    = 1'b1;
    done_early = 1'b0;
    first_v    = 1'b0;
    stable     = 1'b1;
    for (int c = 0; c < t; c++) begin
      if (c % p == 0) begin
        first_v = TxD;
        stable  = 1'b1;
      end else if (TxD !== first_v) begin
        stable = 1'b0;
      end
      if (TxBusy !== 1'b1) busy_ok = 1'b0;
      if (TxDone !== 1'b0) done_early = 1'b1;
      if (c % p == p - 1) begin
        check_eq($sformatf("%s bit%0d", tag, c / p),
                 stable ? {31'd0, first_v} : 32'd2, {31'd0, exp_bits[c / p]});
      end
      if (mode == 1 && c == 40) begin
        TxStart = 1'b1; TxData = ~data; DLS = 2'd0; PEN = ~pen; STOP = ~stop; BaudDiv = 12'd3;
      end
      if (mode == 1 && c == 41) TxStart = 1'b0;
      if (mode == 2 && c == 50) TxEn = 1'b0;
      @(negedge pClk);
    end
    check_eq({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, " no_early_done"}, {31'd0, done_early}, 32'd0);
    check_eq({tag, " done_pulse"}, {31'd0, TxDone}, 32'd1);
    check_eq({tag, " busy_end"}, {31'd0, TxBusy}, 32'd0);
    check_eq({tag, " txd_end"}, {31'd0, TxD}, 32'd1);
  endtask

  initial begin
    logic idle_ok;
    pReset = 1'b0; TxEn = 1'b0; TxStart = 1'b0; TxData = 8'h00; DLS = 2'd0;
    STOP = 1'b0; PEN = 1'b0; EPS = 1'b0; BaudDiv = 12'd0;
    repeat (3) @(negedge pClk);
    check_eq("rst txd", {31'd0, TxD}, 32'd1);
    check_eq("rst busy", {31'd0, TxBusy}, 32'd0);
    check_eq("rst done", {31'd0, TxDone}, 32'd0);
    pReset = 1'b1;
    @(negedge pClk);

    // 8N1, 0xA5, BaudDiv=0: 10 bits of 16 clocks
    run_frame("8N1_A5", 8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 12'd0, 12'h34A, 10, 0);
    @(negedge pClk);
    check_eq("8N1_A5 done_one_cycle", {31'd0, TxDone}, 32'd0);

    // 5E2, 0xFF: parity 1, 9 bits
    run_frame("5E2_FF", 8'hFF, 2'd0, 1'b1, 1'b1, 1'b1, 12'd0, 12'h1FE, 9, 0);
    @(negedge pClk);

    // 8O1, 0x00, BaudDiv=2: parity 1, 11 bits of 48 clocks
    run_frame("8O1_00", 8'h00, 2'd3, 1'b0, 1'b1, 1'b0, 12'd2, 12'h600, 11, 0);
    @(negedge pClk);

    // Mid-frame TxStart and input changes ignored; back-to-back start accepted
    run_frame("IGN_3C", 8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 12'd0, 12'h278, 10, 1);
    run_frame("B2B_81", 8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 12'd0, 12'h302, 10, 0);
    @(negedge pClk);

    // TxStart while disabled is ignored
    TxEn = 1'b0; TxData = 8'h55; TxStart = 1'b1;
    @(negedge pClk);
    TxStart = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (TxD !== 1'b1 || TxBusy !== 1'b0) idle_ok = 1'b0;
      @(negedge pClk);
    end
    check_eq("dis txd_busy_idle", {31'd0, idle_ok}, 32'd1);
    check_eq("dis done", {31'd0, TxDone}, 32'd0);

    // TxEn dropped mid-frame: frame still completes
    run_frame("ENDROP_0F", 8'h0F, 2'd3, 1'b0, 1'b0, 1'b0, 12'd0, 12'h21E, 10, 2);
    @(negedge pClk);

    // Reset during DATA (bit 3 carries data bit 2 of 0xC3, a zero)
    TxEn = 1'b1; TxData = 8'hC3; DLS = 2'd3; STOP = 1'b0; PEN = 1'b0; BaudDiv = 12'd0;
    TxStart = 1'b1;
    @(negedge pClk);
    TxStart = 1'b0;
    repeat (56) @(negedge pClk);
    check_eq("abort pre txd", {31'd0, TxD}, 32'd0);
    check_eq("abort pre busy", {31'd0, TxBusy}, 32'd1);
    #2 pReset = 1'b0;
    #1;
    check_eq("abort txd", {31'd0, TxD}, 32'd1);
    check_eq("abort busy", {31'd0, TxBusy}, 32'd0);
    check_eq("abort done", {31'd0, TxDone}, 32'd0);
    @(negedge pClk);
    pReset = 1'b1;
    @(negedge pClk);
    run_frame("POSTRST_5A", 8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 12'd0, 12'h2B4, 10, 0);
    @(negedge pClk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
